// File: rtl/seg7_digit_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_digit_decoder_if
// Description : Valid/ready result bus carrying one decoded 7-segment digit.
//               The master side (decoder) drives valid/digit/invalid and the
//               slave side (consumer) drives ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_digit_decoder_if;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_digit;
    logic       out_invalid;

    modport master (
        output out_valid,
        output out_digit,
        output out_invalid,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_digit,
        input  out_invalid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/seg7_digit_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_digit_decoder
// Description : Samples an active-low {a,b,c,d,e,f,g} segment bus. A pattern
//               must be seen on STABLE_CYCLES consecutive edges before it is
//               accepted. Each newly accepted pattern is decoded to a BCD
//               digit (4'hF + invalid flag for illegal patterns) and offered
//               on a valid/ready bus. Results arriving while the bus is
//               stalled are dropped and flagged with a one-cycle overrun.
//               Optional macro SEG7_ERRCNT_EN adds a saturating 8-bit count
//               of accepted invalid patterns on port err_count.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_digit_decoder #(
    parameter int STABLE_CYCLES = 4     // legal range 2..255
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic [6:0]            seg_in,
    seg7_digit_decoder_if.master       out_bus,
    output logic                       out_overrun
`ifdef SEG7_ERRCNT_EN
    ,
    output logic [7:0]                 err_count
`endif
);

    localparam logic [6:0] c_BLANK   = 7'b1111111;
    localparam logic [7:0] c_MAX_CNT = 8'(STABLE_CYCLES);
    localparam logic [7:0] c_ACC_CNT = 8'(STABLE_CYCLES - 1);

    logic [6:0] r_s_q;
    logic [7:0] r_stab_cnt;
    logic [6:0] r_last_acc;
    logic       r_out_valid;
    logic [3:0] r_out_digit;
    logic       r_out_invalid;
    logic       r_out_overrun;

    logic       w_same;
    logic       w_accept;
    logic       w_can_load;
    logic [3:0] w_dec_digit;
    logic       w_dec_invalid;
    logic       w_dec_blank;

    // The edge that would make the count reach STABLE_CYCLES is the accept edge.
    assign w_same     = (seg_in == r_s_q);
    assign w_accept   = w_same && (r_stab_cnt == c_ACC_CNT) && (r_s_q != r_last_acc);
    assign w_can_load = !r_out_valid || out_bus.out_ready;

    // Decode the currently held sample; blank is neither a digit nor an error.
    always_comb begin
        w_dec_digit   = 4'hF;
        w_dec_invalid = 1'b0;
        w_dec_blank   = 1'b0;
        case (r_s_q)
            7'b0000001: w_dec_digit = 4'd0;
            7'b1001111: w_dec_digit = 4'd1;
            7'b0010010: w_dec_digit = 4'd2;
            7'b0000110: w_dec_digit = 4'd3;
            7'b1001100: w_dec_digit = 4'd4;
            7'b0100100: w_dec_digit = 4'd5;
            7'b0100000: w_dec_digit = 4'd6;
            7'b0001111: w_dec_digit = 4'd7;
            7'b0000000: w_dec_digit = 4'd8;
            7'b0000100: w_dec_digit = 4'd9;
            c_BLANK:    w_dec_blank = 1'b1;
            default:    w_dec_invalid = 1'b1;
        endcase
    end

    // Glitch filter: restart the run length on any change, saturate at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_q      <= c_BLANK;
            r_stab_cnt <= 8'd0;
            r_last_acc <= c_BLANK;
        end else begin
            if (!w_same) begin
                r_s_q      <= seg_in;
                r_stab_cnt <= 8'd1;
            end else if (r_stab_cnt < c_MAX_CNT) begin
                r_stab_cnt <= r_stab_cnt + 8'd1;
            end
            if (w_accept) begin
                r_last_acc <= r_s_q;
            end
        end
    end

    // Output register: load on accept when free (or draining), else drop and flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_digit   <= 4'd0;
            r_out_invalid <= 1'b0;
            r_out_overrun <= 1'b0;
        end else begin
            r_out_overrun <= 1'b0;
            if (w_accept && !w_dec_blank && w_can_load) begin
                r_out_valid   <= 1'b1;
                r_out_digit   <= w_dec_digit;
                r_out_invalid <= w_dec_invalid;
            end else begin
                if (r_out_valid && out_bus.out_ready) begin
                    r_out_valid <= 1'b0;
                end
                if (w_accept && !w_dec_blank) begin
                    r_out_overrun <= 1'b1;
                end
            end
        end
    end

`ifdef SEG7_ERRCNT_EN
    logic [7:0] r_err_count;

    // Count every accepted invalid pattern, delivered or dropped, saturating at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= 8'd0;
        end else if (w_accept && w_dec_invalid && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign out_bus.out_valid   = r_out_valid;
    assign out_bus.out_digit   = r_out_digit;
    assign out_bus.out_invalid = r_out_invalid;
    assign out_overrun         = r_out_overrun;

endmodule
`default_nettype wire

// File: tb/tb_seg7_digit_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_digit_decoder
// Description : Directed self-checking bench for seg7_digit_decoder with the
//               default STABLE_CYCLES of 4. Inputs change and outputs are
//               sampled 1 time unit after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_digit_decoder;

    logic       clk;
    logic       reset;
    logic [6:0] seg_in;
    logic       out_overrun;
`ifdef SEG7_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int checks;
    int errors;

    seg7_digit_decoder_if bus ();

    seg7_digit_decoder #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .out_bus     (bus.master),
        .out_overrun (out_overrun)
`ifdef SEG7_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] pat [10];
    initial begin
        pat[0] = 7'b0000001; pat[1] = 7'b1001111; pat[2] = 7'b0010010;
        pat[3] = 7'b0000110; pat[4] = 7'b1001100; pat[5] = 7'b0100100;
        pat[6] = 7'b0100000; pat[7] = 7'b0001111; pat[8] = 7'b0000000;
        pat[9] = 7'b0000100;
    end

    // Advance one edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; seg_in = 7'b1111111; bus.out_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        checks++;
        if (bus.out_digit !== 4'd0) begin errors++; $display("FAIL reset_digit got %h want 0", bus.out_digit); end
        checks++;
        if (bus.out_invalid !== 1'b0 || out_overrun !== 1'b0) begin
            errors++; $display("FAIL reset_flags got inv=%b ovr=%b want 0 0", bus.out_invalid, out_overrun);
        end
`ifdef SEG7_ERRCNT_EN
        checks++;
        if (err_count !== 8'd0) begin errors++; $display("FAIL reset_errcnt got %0d want 0", err_count); end
`endif
    endtask

    task automatic test_single_digit();
        seg_in = 7'b0000110;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (bus.out_valid !== (i == 4)) begin
                errors++; $display("FAIL single_valid edge %0d got %b want %b", i, bus.out_valid, (i == 4));
            end
            if (i == 4) begin
                checks++;
                if (bus.out_digit !== 4'd3 || bus.out_invalid !== 1'b0) begin
                    errors++; $display("FAIL single_digit got %h inv %b want 3 inv 0", bus.out_digit, bus.out_invalid);
                end
            end
        end
    endtask

    task automatic test_digit_sweep();
        for (int d = 0; d < 10; d++) begin
            seg_in = pat[d];
            for (int i = 1; i <= 6; i++) begin
                step();
                checks++;
                if (bus.out_valid !== (i == 4)) begin
                    errors++; $display("FAIL sweep_valid digit %0d edge %0d got %b want %b", d, i, bus.out_valid, (i == 4));
                end
                if (i == 4) begin
                    checks++;
                    if (bus.out_digit !== 4'(d) || bus.out_invalid !== 1'b0) begin
                        errors++; $display("FAIL sweep_digit got %h inv %b want %0d inv 0", bus.out_digit, bus.out_invalid, d);
                    end
                end
            end
        end
    endtask

    task automatic test_glitch();
        int pulses;
        logic [3:0] seen;
        pulses = 0; seen = 4'h0;
        for (int i = 0; i < 12; i++) begin
            seg_in = (i >= 4 && i < 6) ? 7'b1111110 : 7'b0010010;
            step();
            if (bus.out_valid) begin pulses++; seen = bus.out_digit; end
            checks++;
            if (out_overrun !== 1'b0) begin errors++; $display("FAIL glitch_overrun cycle %0d got 1 want 0", i); end
        end
        checks++;
        if (pulses != 1 || seen !== 4'd2) begin
            errors++; $display("FAIL glitch_result got %0d pulses digit %h want 1 pulse digit 2", pulses, seen);
        end
`ifdef SEG7_ERRCNT_EN
        checks++;
        if (err_count !== 8'd0) begin errors++; $display("FAIL glitch_errcnt got %0d want 0", err_count); end
`endif
    endtask

    task automatic test_overrun();
        int ovr;
        bus.out_ready = 1'b0;
        seg_in = pat[1];
        for (int i = 1; i <= 5; i++) step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'd1) begin
            errors++; $display("FAIL ovr_first got v=%b d=%h want v=1 d=1", bus.out_valid, bus.out_digit);
        end
        ovr = 0;
        seg_in = pat[2];
        for (int i = 1; i <= 5; i++) begin
            step();
            if (out_overrun) ovr++;
            checks++;
            if (out_overrun !== (i == 4)) begin
                errors++; $display("FAIL ovr_pulse edge %0d got %b want %b", i, out_overrun, (i == 4));
            end
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'd1) begin
                errors++; $display("FAIL ovr_hold edge %0d got v=%b d=%h want v=1 d=1", i, bus.out_valid, bus.out_digit);
            end
        end
        checks++;
        if (ovr != 1) begin errors++; $display("FAIL ovr_count got %0d want 1", ovr); end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_blank();
        seg_in = 7'b1111111;
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL blank_valid edge %0d got 1 want 0", i); end
        end
        seg_in = pat[2];
        for (int i = 1; i <= 4; i++) step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'd2) begin
            errors++; $display("FAIL blank_reaccept got v=%b d=%h want v=1 d=2", bus.out_valid, bus.out_digit);
        end
        step();
    endtask

    task automatic test_invalid();
        int bad;
        seg_in = 7'b1110000;
        for (int i = 1; i <= 4; i++) step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'hF || bus.out_invalid !== 1'b1) begin
            errors++; $display("FAIL invalid_first got v=%b d=%h inv=%b want 1 f 1", bus.out_valid, bus.out_digit, bus.out_invalid);
        end
`ifdef SEG7_ERRCNT_EN
        checks++;
        if (err_count !== 8'd1) begin errors++; $display("FAIL invalid_errcnt got %0d want 1", err_count); end
`endif
        step();
        bad = 0;
        for (int p = 0; p < 300; p++) begin
            seg_in = p[0] ? 7'b1110000 : 7'b1110001;
            for (int i = 1; i <= 4; i++) begin
                step();
                if (bus.out_valid && bus.out_invalid && bus.out_digit == 4'hF) bad++;
            end
        end
        checks++;
        if (bad != 300) begin errors++; $display("FAIL invalid_stream got %0d results want 300", bad); end
`ifdef SEG7_ERRCNT_EN
        checks++;
        if (err_count !== 8'd255) begin errors++; $display("FAIL errcnt_sat got %0d want 255", err_count); end
`endif
        step();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        seg_in = pat[5];
        for (int i = 1; i <= 4; i++) step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'd5) begin
            errors++; $display("FAIL mid_pending got v=%b d=%h want v=1 d=5", bus.out_valid, bus.out_digit);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_digit !== 4'd0) begin
            errors++; $display("FAIL mid_reset got v=%b d=%h want v=0 d=0", bus.out_valid, bus.out_digit);
        end
`ifdef SEG7_ERRCNT_EN
        checks++;
        if (err_count !== 8'd0) begin errors++; $display("FAIL mid_errcnt got %0d want 0", err_count); end
`endif
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (bus.out_valid !== (i == 4)) begin
                errors++; $display("FAIL mid_reaccept edge %0d got %b want %b", i, bus.out_valid, (i == 4));
            end
        end
        checks++;
        if (bus.out_digit !== 4'd5) begin errors++; $display("FAIL mid_digit got %h want 5", bus.out_digit); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        seg_in = 7'b1111111;
        bus.out_ready = 1'b1;
        #1;
        test_reset();
        test_single_digit();
        test_digit_sweep();
        test_glitch();
        test_overrun();
        test_blank();
        test_invalid();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_digit_decoder.md
# seg7_digit_decoder

Receive-side counterpart to the team's 7-segment display encoders. It samples an active-low 7-segment pattern bus and rejects glitches by requiring the pattern to hold for a programmable number of cycles. Each newly stable pattern is decoded to a BCD digit and delivered over a valid/ready output. It sits between a board-level segment bus (or an encoder under test) and checking/logging logic.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted; legal range 2..255.
- clk  input  1  rising-edge clock; all state updates here.
- reset  input  1  synchronous, active-high reset.
- seg_in  input  7  segment pattern, ordered {a,b,c,d,e,f,g}, active-low (0 = segment lit); asynchronous to the producer, sampled every edge.
- out_ready  input  1  consumer accepts out_digit this cycle.
- out_valid  output  1  out_digit/out_invalid hold a decoded result.
- out_digit  output  4  decoded digit 0..9; 4'hF when the pattern is invalid.
- out_invalid  output  1  accepted pattern is not a legal digit.
- out_overrun  output  1  one-cycle pulse; a result was dropped because the output was still occupied.
- err_count  output  8  saturating invalid-pattern count; present only with SEG7_ERRCNT_EN.

## Operation
- Registers:
  - s_q (7b): last sample.
  - stab_cnt: 0..STABLE_CYCLES.
  - last_acc (7b): last accepted pattern.
  - Output register: out_valid, out_digit, out_invalid.
- Reset values:
  - s_q = 7'b1111111, stab_cnt = 0, last_acc = 7'b1111111.
  - out_valid = 0, out_digit = 0, out_invalid = 0, out_overrun = 0, err_count = 0.
- Filter, evaluated each edge:
  - seg_in != s_q: s_q <= seg_in, stab_cnt <= 1.
  - Otherwise, if stab_cnt < STABLE_CYCLES: stab_cnt <= stab_cnt + 1.
  - Otherwise: hold.
- Acceptance event:
  - Condition: on the edge where seg_in == s_q and stab_cnt == STABLE_CYCLES-1, and s_q != last_acc.
  - On that edge last_acc <= s_q.
  - A pattern that stays stable is never accepted twice; it must change and re-stabilise first.
- Decode table (active-low {a..g}):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
- Blank 7'b1111111: accepted (updates last_acc) but produces no output and is not an error.
- Any other pattern: out_digit = 4'hF, out_invalid = 1.
- Output handshake:
  - Transfer occurs when out_valid && out_ready; out_valid clears on that edge unless reloaded.
  - Acceptance with out_valid == 0, or out_valid && out_ready in the same cycle: the output register is loaded and out_valid = 1 (back-to-back allowed).
  - Acceptance with out_valid && !out_ready: the new result is dropped, out_overrun pulses high for one cycle, the held output is unchanged, and last_acc still updates.
  - out_digit and out_invalid stay stable while out_valid && !out_ready.
- Reset mid-operation: all state returns to reset values on the next edge, regardless of out_ready; a pending result is lost.

## Timing
- All outputs registered; no combinational path from any input to any output.
- Latency: a new pattern first sampled at edge E0 produces out_valid = 1 after edge E0 + STABLE_CYCLES - 1 (the STABLE_CYCLES-th consecutive sampling edge). Default 4 means valid after the 4th edge.
- A glitch shorter than STABLE_CYCLES edges restarts the count and produces no output.
- out_overrun is asserted for exactly one cycle per dropped result.

## Configuration
- SEG7_ERRCNT_EN defined:
  - err_count is present.
  - It increments by 1 on each accepted invalid pattern, whether the result was delivered or dropped by overrun.
  - It saturates at 255 and clears only on reset.
- SEG7_ERRCNT_EN undefined:
  - err_count port and counter logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then hold seg_in = 7'b0000110 with out_ready = 1 -> out_valid high for one cycle after the 4th edge with out_digit = 3, out_invalid = 0; no further outputs while the pattern is held.
- Sweep the ten digit patterns, each held 6 cycles, out_ready = 1 -> out_digit sequence 0..9, each valid one cycle, each 4 edges after its pattern change.
- Hold 7'b0010010 for 4 cycles, glitch to 7'b1111110 for 2 cycles, return -> exactly one result, digit 2; the glitch produces no output and no count.
- Hold out_ready = 0, apply 1 then 2 (each 5 cycles) -> out_digit stays 1, out_overrun pulses once when 2 is accepted; raise out_ready -> 1 transfers and out_valid drops.
- Apply 7'b1110000 -> out_digit = 4'hF, out_invalid = 1; with SEG7_ERRCNT_EN, err_count = 1; after 300 alternating invalid patterns (1110000/1110001), err_count = 255.
- Assert reset while out_valid = 1 and out_ready = 0 -> out_valid = 0 after the next edge; reapplying the same digit is accepted again.
